mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: mode names, FSM encoding, width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_arb_pkg;

  // Arbitration mode names accepted by the MODE parameter.
  localparam string MODE_FIXED = "FIXED";
  localparam string MODE_RR    = "RR";

  // IDLE: grant goes to the arbitration winner. LOCKED: only the owner may be granted.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Width of a channel index (owner, round-robin pointer). Never narrower than 1 bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a wait counter that must be able to hold the value STARVE.
  function automatic int cnt_w(input int starve);
    return (starve > 0) ? $clog2(starve + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Rotating-base priority picker: first set request at or above base, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   req  - request vector, one bit per channel
//   base - index searched first; higher indices follow, then wrap to 0
//   gnt  - one-hot winner, all zero when req is zero
module arb_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(base) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NCH channels onto one single-cycle memory port (FIXED priority w/ starvation guard, or RR), with lock.
// Latency: grant, address, enables and read data are all combinational; the access completes in the grant cycle.
// Backpressure: non-granted requesters see o_stall; i_mem_stall blocks every grant and freezes all state.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   i_req/i_we/i_lock   - per-channel request, write-not-read, keep ownership after this access
//   i_addr/i_wdata      - per-channel address/data, channel k at [k*W +: W]
//   o_gnt/o_stall       - one-hot grant, request pending but not granted
//   o_rvalid/o_rdata    - read completion per channel, shared read data
//   o_busy              - arbiter is LOCKED to an owner
//   i_mem_stall         - memory cannot accept an access this cycle
//   o_read_en/o_write_en/o_memaddr/o_write_data/i_read_data - memory side
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int    NCH    = 2,
  parameter int    AW     = 32,
  parameter int    DW     = 32,
  parameter string MODE   = "FIXED",
  parameter int    STARVE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH-1:0]    i_we,
  input  logic [NCH-1:0]    i_lock,
  input  logic [NCH*AW-1:0] i_addr,
  input  logic [NCH*DW-1:0] i_wdata,
  output logic [NCH-1:0]    o_gnt,
  output logic [NCH-1:0]    o_stall,
  output logic [NCH-1:0]    o_rvalid,
  output logic [DW-1:0]     o_rdata,
  output logic              o_busy,
  input  logic              i_mem_stall,
  output logic              o_read_en,
  output logic              o_write_en,
  output logic [AW-1:0]     o_memaddr,
  output logic [DW-1:0]     o_write_data,
  input  logic [DW-1:0]     i_read_data
);

  localparam int IW    = owner_w(NCH);
  localparam int CW    = cnt_w(STARVE);
  localparam bit IS_RR = (MODE == MODE_RR);

  state_t         state;
  logic [IW-1:0]  owner;
  logic [IW-1:0]  ptr;
  logic [CW-1:0]  wait_cnt [NCH];

  logic [NCH-1:0] urgent;
  logic [NCH-1:0] pick_req;
  logic [IW-1:0]  pick_base;
  logic [NCH-1:0] pick_gnt;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  gidx;
  logic [AW-1:0]  memaddr;
  logic [DW-1:0]  wdata;

  // A channel is urgent once it has waited STARVE cycles; STARVE=0 disables the guard.
  always_comb begin
    urgent = '0;
    for (int k = 0; k < NCH; k++) begin
      urgent[k] = (STARVE != 0) && (wait_cnt[k] == CW'(STARVE));
    end
  end

  // FIXED searches from 0, restricted to urgent channels when any of them request.
  // RR searches from the rotating pointer and ignores urgency.
  always_comb begin
    pick_req  = i_req;
    pick_base = '0;
    if (IS_RR) begin
      pick_base = ptr;
    end else if (|(i_req & urgent)) begin
      pick_req = i_req & urgent;
    end
  end

  arb_pick #(
    .N  (NCH),
    .IW (IW)
  ) u_pick (
    .req  (pick_req),
    .base (pick_base),
    .gnt  (pick_gnt)
  );

  // Reset is folded in combinationally so no grant leaks out while rst is low.
  always_comb begin
    gnt = '0;
    if (rst && !i_mem_stall) begin
      if (state == ST_LOCKED) begin
        gnt[owner] = i_req[owner];
      end else begin
        gnt = pick_gnt;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) gidx = IW'(k);
    end
  end

  // One-hot AND-OR mux; with no grant both buses fall to zero.
  always_comb begin
    memaddr = '0;
    wdata   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) begin
        memaddr = memaddr | i_addr[k*AW +: AW];
        wdata   = wdata | i_wdata[k*DW +: DW];
      end
    end
  end

  assign o_gnt        = gnt;
  assign o_stall      = i_req & ~gnt;
  assign o_rvalid     = gnt & ~i_we;
  assign o_rdata      = i_read_data;
  assign o_busy       = (state == ST_LOCKED);
  assign o_read_en    = |(gnt & ~i_we);
  assign o_write_en   = |(gnt & i_we);
  assign o_memaddr    = memaddr;
  assign o_write_data = wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
      for (int k = 0; k < NCH; k++) wait_cnt[k] <= '0;
    end else if (!i_mem_stall) begin
      case (state)
        ST_IDLE: begin
          // Only the granted channel's lock bit matters.
          if (|(gnt & i_lock)) begin
            state <= ST_LOCKED;
            owner <= gidx;
          end
        end
        ST_LOCKED: begin
          if (!i_req[owner] || (gnt[owner] && !i_lock[owner])) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // The pointer only rotates on arbitrated grants, never on owner accesses.
      if (IS_RR && (state == ST_IDLE) && (|gnt)) begin
        ptr <= (gidx == IW'(NCH - 1)) ? '0 : gidx + 1'b1;
      end

      if (!IS_RR) begin
        for (int k = 0; k < NCH; k++) begin
          if (gnt[k]) begin
            wait_cnt[k] <= '0;
          end else if (i_req[k] && !((state == ST_LOCKED) && (owner == IW'(k)))
                       && (wait_cnt[k] != CW'(STARVE))) begin
            wait_cnt[k] <= wait_cnt[k] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a FIXED/NCH=2/STARVE=4 instance and an RR/NCH=4 instance.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Expected values are written out by hand per cycle.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // FIXED instance
  logic [1:0]  f_req, f_we, f_lock, f_gnt, f_stall, f_rvalid;
  logic [63:0] f_addr, f_wdata;
  logic [31:0] f_rdata, f_maddr, f_wd, f_rd;
  logic        f_busy, f_mstall, f_ren, f_wen;

  // RR instance
  logic [3:0]   r_req, r_we, r_lock, r_gnt, r_stall, r_rvalid;
  logic [127:0] r_addr, r_wdata;
  logic [31:0]  r_rdata, r_maddr, r_wd, r_rd;
  logic         r_busy, r_mstall, r_ren, r_wen;

  mem_arbiter #(.NCH(2), .AW(32), .DW(32), .MODE("FIXED"), .STARVE(4)) u_fix (
    .clk(clk), .rst(rst), .i_req(f_req), .i_we(f_we), .i_lock(f_lock),
    .i_addr(f_addr), .i_wdata(f_wdata), .o_gnt(f_gnt), .o_stall(f_stall),
    .o_rvalid(f_rvalid), .o_rdata(f_rdata), .o_busy(f_busy), .i_mem_stall(f_mstall),
    .o_read_en(f_ren), .o_write_en(f_wen), .o_memaddr(f_maddr),
    .o_write_data(f_wd), .i_read_data(f_rd)
  );

  mem_arbiter #(.NCH(4), .AW(32), .DW(32), .MODE("RR"), .STARVE(8)) u_rr (
    .clk(clk), .rst(rst), .i_req(r_req), .i_we(r_we), .i_lock(r_lock),
    .i_addr(r_addr), .i_wdata(r_wdata), .o_gnt(r_gnt), .o_stall(r_stall),
    .o_rvalid(r_rvalid), .o_rdata(r_rdata), .o_busy(r_busy), .i_mem_stall(r_mstall),
    .o_read_en(r_ren), .o_write_en(r_wen), .o_memaddr(r_maddr),
    .o_write_data(r_wd), .i_read_data(r_rd)
  );

  // Lock scenario, FIXED instance, one entry per cycle.
  localparam logic [1:0] LK_REQ  [8] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b01};
  localparam logic [1:0] LK_LOCK [8] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [1:0] LK_GNT  [8] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01};
  localparam logic       LK_BUSY [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic zero_inputs;
    f_req = '0; f_we = '0; f_lock = '0; f_addr = '0; f_wdata = '0; f_mstall = 1'b0; f_rd = '0;
    r_req = '0; r_we = '0; r_lock = '0; r_addr = '0; r_wdata = '0; r_mstall = 1'b0; r_rd = '0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    zero_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    zero_inputs();
    rst   = 1'b0;
    f_req = 2'b11;
    r_req = 4'b1111;
    @(negedge clk);
    #1;
    n_chk++;
    if (f_gnt !== 2'b00 || f_rvalid !== 2'b00 || f_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_fix_gnt: gnt=%b rvalid=%b busy=%b, want 00/00/0", f_gnt, f_rvalid, f_busy);
    end
    n_chk++;
    if (f_ren !== 1'b0 || f_wen !== 1'b0 || f_maddr !== 32'h0 || f_wd !== 32'h0) begin
      n_fail++; $display("FAIL reset_fix_mem: ren=%b wen=%b addr=%h wd=%h, want all 0", f_ren, f_wen, f_maddr, f_wd);
    end
    n_chk++;
    if (f_stall !== 2'b11 || r_stall !== 4'b1111) begin
      n_fail++; $display("FAIL reset_stall: fix=%b rr=%b, want 11/1111", f_stall, r_stall);
    end
    n_chk++;
    if (r_gnt !== 4'b0000 || r_busy !== 1'b0 || u_rr.ptr !== 2'd0) begin
      n_fail++; $display("FAIL reset_rr: gnt=%b busy=%b ptr=%0d, want 0000/0/0", r_gnt, r_busy, u_rr.ptr);
    end
  endtask

  task automatic test_fixed_priority;
    do_reset();
    f_addr = {32'h0000_0200, 32'h0000_0100};
    f_rd   = 32'hDEAD_BEEF;
    f_req  = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (f_gnt !== 2'b01 || f_stall !== 2'b10) begin
        n_fail++; $display("FAIL fixed_gnt c%0d: gnt=%b stall=%b, want 01/10", c, f_gnt, f_stall);
      end
      n_chk++;
      if (f_maddr !== 32'h100 || f_ren !== 1'b1 || f_wen !== 1'b0) begin
        n_fail++; $display("FAIL fixed_mem c%0d: addr=%h ren=%b wen=%b, want 100/1/0", c, f_maddr, f_ren, f_wen);
      end
      n_chk++;
      if (f_rvalid !== 2'b01 || f_rdata !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL fixed_rdata c%0d: rvalid=%b rdata=%h, want 01/deadbeef", c, f_rvalid, f_rdata);
      end
      @(negedge clk);
    end
    f_req = 2'b00;
    #1;
    n_chk++;
    if (f_gnt !== 2'b00 || f_ren !== 1'b0 || f_maddr !== 32'h0 || f_wd !== 32'h0) begin
      n_fail++; $display("FAIL fixed_idle: gnt=%b ren=%b addr=%h wd=%h, want all 0", f_gnt, f_ren, f_maddr, f_wd);
    end
    @(negedge clk);
  endtask

  task automatic test_starve;
    logic [1:0] exp_gnt [6];
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    do_reset();
    f_addr  = {32'h0000_0200, 32'h0000_0100};
    f_wdata = {32'hCAFE_0001, 32'h1111_1111};
    f_we    = 2'b10;
    f_req   = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_chk++;
      if (f_gnt !== exp_gnt[c]) begin
        n_fail++; $display("FAIL starve_gnt c%0d: gnt=%b want %b", c, f_gnt, exp_gnt[c]);
      end
      if (c == 4) begin
        n_chk++;
        if (f_wen !== 1'b1 || f_ren !== 1'b0 || f_wd !== 32'hCAFE_0001 || f_maddr !== 32'h200 || f_rvalid !== 2'b00) begin
          n_fail++; $display("FAIL starve_write: wen=%b ren=%b wd=%h addr=%h rvalid=%b, want 1/0/cafe0001/200/00",
                             f_wen, f_ren, f_wd, f_maddr, f_rvalid);
        end
      end
      @(negedge clk);
    end
    f_req = 2'b00;
    f_we  = 2'b00;
  endtask

  task automatic test_lock;
    do_reset();
    f_addr = {32'h0000_0200, 32'h0000_0100};
    for (int c = 0; c < 8; c++) begin
      f_req  = LK_REQ[c];
      f_lock = LK_LOCK[c];
      #1;
      n_chk++;
      if (f_gnt !== LK_GNT[c] || f_busy !== LK_BUSY[c] || f_stall !== (LK_REQ[c] & ~LK_GNT[c])) begin
        n_fail++; $display("FAIL lock c%0d: gnt=%b busy=%b stall=%b, want %b/%b/%b", c, f_gnt, f_busy, f_stall,
                           LK_GNT[c], LK_BUSY[c], LK_REQ[c] & ~LK_GNT[c]);
      end
      @(negedge clk);
    end
    f_req  = 2'b00;
    f_lock = 2'b00;
  endtask

  task automatic test_mem_stall;
    logic       ms      [7];
    logic [1:0] exp_gnt [7];
    ms      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_gnt = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    do_reset();
    f_addr = {32'h0000_0200, 32'h0000_0100};
    f_req  = 2'b11;
    for (int c = 0; c < 7; c++) begin
      f_mstall = ms[c];
      #1;
      n_chk++;
      if (f_gnt !== exp_gnt[c] || f_stall !== ~exp_gnt[c]) begin
        n_fail++; $display("FAIL mstall_gnt c%0d: gnt=%b stall=%b, want %b/%b", c, f_gnt, f_stall, exp_gnt[c], ~exp_gnt[c]);
      end
      if (ms[c]) begin
        n_chk++;
        if (f_ren !== 1'b0 || f_wen !== 1'b0 || f_maddr !== 32'h0) begin
          n_fail++; $display("FAIL mstall_en c%0d: ren=%b wen=%b addr=%h, want 0/0/0", c, f_ren, f_wen, f_maddr);
        end
      end
      @(negedge clk);
    end
    f_req    = 2'b00;
    f_mstall = 1'b0;
  endtask

  task automatic test_rr;
    logic [3:0] rq    [7];
    logic [3:0] exp_g [7];
    logic [1:0] exp_p [7];
    rq    = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0101, 4'b0011};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0001};
    exp_p = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3};
    do_reset();
    r_addr = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    for (int c = 0; c < 7; c++) begin
      r_req = rq[c];
      #1;
      n_chk++;
      if (r_gnt !== exp_g[c] || u_rr.ptr !== exp_p[c]) begin
        n_fail++; $display("FAIL rr c%0d: gnt=%b ptr=%0d, want %b/%0d", c, r_gnt, u_rr.ptr, exp_g[c], exp_p[c]);
      end
      if (c < 4) begin
        n_chk++;
        if (r_maddr !== 32'h1000 * (c + 1)) begin
          n_fail++; $display("FAIL rr_addr c%0d: addr=%h want %h", c, r_maddr, 32'h1000 * (c + 1));
        end
      end
      @(negedge clk);
    end
    r_req = 4'b0000;
  endtask

  task automatic test_reset_locked;
    do_reset();
    r_req  = 4'b0100;
    r_lock = 4'b0100;
    #1;
    n_chk++;
    if (r_gnt !== 4'b0100 || r_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstlk_first: gnt=%b busy=%b, want 0100/0", r_gnt, r_busy);
    end
    @(negedge clk);
    r_req = 4'b0111;
    #1;
    n_chk++;
    if (r_gnt !== 4'b0100 || r_stall !== 4'b0011 || r_busy !== 1'b1 || u_rr.ptr !== 2'd3) begin
      n_fail++; $display("FAIL rstlk_locked: gnt=%b stall=%b busy=%b ptr=%0d, want 0100/0011/1/3",
                         r_gnt, r_stall, r_busy, u_rr.ptr);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (r_busy !== 1'b0 || u_rr.ptr !== 2'd0 || r_gnt !== 4'b0000 || r_stall !== 4'b0111) begin
      n_fail++; $display("FAIL rstlk_inreset: busy=%b ptr=%0d gnt=%b stall=%b, want 0/0/0000/0111",
                         r_busy, u_rr.ptr, r_gnt, r_stall);
    end
    @(negedge clk);
    rst    = 1'b1;
    r_req  = 4'b0001;
    r_lock = 4'b0000;
    #1;
    n_chk++;
    if (r_gnt !== 4'b0001 || r_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstlk_release: gnt=%b busy=%b, want 0001/0", r_gnt, r_busy);
    end
    @(negedge clk);
    r_req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_starve();
    test_lock();
    test_mem_stall();
    test_rr();
    test_reset_locked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
